// File: rtl/pc_gen.sv
// pc_gen: program counter generator with trap/branch/call/return redirects and a circular return-address stack
module pc_gen #(
  parameter int XLEN = 64,
  parameter int INC = 4,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter logic [XLEN-1:0] TRAP_VEC = XLEN'('h100),
  parameter int RAS_DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic stall,
  input  logic trap,
  input  logic br_taken,
  input  logic [XLEN-1:0] br_target,
  input  logic call,
  input  logic ret,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] pc_next,
  output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count,
  output logic err
);
  localparam int CW = $clog2(RAS_DEPTH + 1);
  localparam int PW = $clog2(RAS_DEPTH);
  logic [XLEN-1:0] ras [RAS_DEPTH];
  logic [PW-1:0] ptr;
  logic [XLEN-1:0] seq, top;
  logic act, push, pop, err_next;
  always_comb begin
    seq = pc_out + XLEN'(INC);
    top = ras[ptr - PW'(1)];
    act = !trap && !stall && !br_taken;
    push = act && !ret && call;
    pop = act && ret && ras_count != '0;
    pc_next = rst ? RESET_VEC : trap ? TRAP_VEC : stall ? pc_out : br_taken ? br_target :
              ret ? (ras_count != '0 ? top : seq) : call ? br_target : seq;
    err_next = trap ? 1'b0 : stall ? err : (!br_taken && ret && (call || ras_count == '0));
  end
  always_ff @(posedge clk) begin
    pc_out <= pc_next;
    if (rst) begin
      ras_count <= '0;
      ptr <= '0;
      err <= 1'b0;
    end else begin
      err <= err_next;
      if (push) begin
        ptr <= ptr + PW'(1);
        if (ras_count != CW'(RAS_DEPTH)) ras_count <= ras_count + CW'(1);
      end else if (pop) begin
        ptr <= ptr - PW'(1);
        ras_count <= ras_count - CW'(1);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst && push) ras[ptr] <= seq;
  end
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed self-checking bench for pc_gen
module tb_pc_gen;
  logic clk = 1'b0;
  logic rst, stall, trap, br_taken, call, ret;
  logic [63:0] br_target, pc_out, pc_next;
  logic [2:0] ras_count;
  logic err;
  logic rst8, br8;
  logic [7:0] tgt8, pc8, pcn8;
  logic [2:0] cnt8;
  logic err8;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  pc_gen dut (.clk(clk), .rst(rst), .stall(stall), .trap(trap), .br_taken(br_taken),
    .br_target(br_target), .call(call), .ret(ret), .pc_out(pc_out), .pc_next(pc_next),
    .ras_count(ras_count), .err(err));
  pc_gen #(.XLEN(8)) dut8 (.clk(clk), .rst(rst8), .stall(1'b0), .trap(1'b0), .br_taken(br8),
    .br_target(tgt8), .call(1'b0), .ret(1'b0), .pc_out(pc8), .pc_next(pcn8),
    .ras_count(cnt8), .err(err8));
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic idle();
    {stall, trap, br_taken, call, ret} = '0;
    br_target = '0;
  endtask
  initial begin
    idle();
    rst = 1'b1;
    rst8 = 1'b1;
    br8 = 1'b0;
    tgt8 = '0;
    tick();
    chk("rst_pc", pc_out, 64'h0);
    chk("rst_cnt", 64'(ras_count), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    rst = 1'b0;
    rst8 = 1'b0;
    #1 chk("seq_pc_next", pc_next, 64'h4);
    tick();
    chk("run_pc4", pc_out, 64'h4);
    tick();
    chk("run_pc8", pc_out, 64'h8);
    call = 1'b1;
    br_target = 64'h40;
    #1 chk("call_pc_next", pc_next, 64'h40);
    tick();
    chk("call_pc", pc_out, 64'h40);
    chk("call_cnt", 64'(ras_count), 64'd1);
    idle();
    tick();
    chk("after_call_seq", pc_out, 64'h44);
    ret = 1'b1;
    tick();
    chk("ret_pc", pc_out, 64'hC);
    chk("ret_cnt", 64'(ras_count), 64'd0);
    chk("ret_err", 64'(err), 64'd0);
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      call = 1'b1;
      br_target = 64'((i + 1) * 'h100);
      tick();
      chk("ovf_call_pc", pc_out, 64'((i + 1) * 'h100));
      chk("ovf_call_cnt", 64'(ras_count), 64'(i < 3 ? i + 1 : 4));
      chk("ovf_call_err", 64'(err), 64'd0);
    end
    idle();
    ret = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("pop_pc", pc_out, 64'(('h404) - i * 'h100));
      chk("pop_cnt", 64'(ras_count), 64'(3 - i));
      chk("pop_err", 64'(err), 64'd0);
    end
    tick();
    chk("undf_pc", pc_out, 64'h108);
    chk("undf_cnt", 64'(ras_count), 64'd0);
    chk("undf_err", 64'(err), 64'd1);
    idle();
    tick();
    chk("undf_err_clr", 64'(err), 64'd0);
    chk("undf_seq", pc_out, 64'h10C);
    br_taken = 1'b1;
    call = 1'b1;
    br_target = 64'h20;
    tick();
    chk("br_pc", pc_out, 64'h20);
    chk("br_ignores_call", 64'(ras_count), 64'd0);
    chk("br_no_err", 64'(err), 64'd0);
    br_target = 64'h999;
    stall = 1'b1;
    tick();
    chk("stall1_pc", pc_out, 64'h20);
    chk("stall1_cnt", 64'(ras_count), 64'd0);
    tick();
    chk("stall2_pc", pc_out, 64'h20);
    trap = 1'b1;
    #1 chk("trap_pc_next", pc_next, 64'h100);
    tick();
    chk("trap_pc", pc_out, 64'h100);
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    call = 1'b1;
    br_target = 64'h1000;
    tick();
    idle();
    br_taken = 1'b1;
    br_target = 64'h4C;
    tick();
    chk("setup_pc", pc_out, 64'h4C);
    idle();
    call = 1'b1;
    br_target = 64'h200;
    tick();
    chk("setup_cnt", 64'(ras_count), 64'd2);
    ret = 1'b1;
    tick();
    chk("callret_pc", pc_out, 64'h50);
    chk("callret_cnt", 64'(ras_count), 64'd1);
    chk("callret_err", 64'(err), 64'd1);
    idle();
    tick();
    chk("callret_err_clr", 64'(err), 64'd0);
    chk("callret_seq", pc_out, 64'h54);
    ret = 1'b1;
    tick();
    chk("deep_ret_pc", pc_out, 64'h4);
    chk("deep_ret_cnt", 64'(ras_count), 64'd0);
    idle();
    call = 1'b1;
    br_target = 64'h300;
    for (int i = 0; i < 4; i++) tick();
    chk("full_cnt", 64'(ras_count), 64'd4);
    idle();
    stall = 1'b1;
    rst = 1'b1;
    tick();
    chk("rst_stall_pc", pc_out, 64'h0);
    chk("rst_full_cnt", 64'(ras_count), 64'd0);
    rst = 1'b0;
    idle();
    br8 = 1'b1;
    tgt8 = 8'hFC;
    tick();
    chk("x8_pc_fc", 64'(pc8), 64'hFC);
    br8 = 1'b0;
    #1 chk("x8_pc_next_wrap", 64'(pcn8), 64'h00);
    tick();
    chk("x8_wrap_pc", 64'(pc8), 64'h00);
    chk("x8_wrap_err", 64'(err8), 64'd0);
    chk("x8_cnt", 64'(cnt8), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
